yarp_instr_mem_responder: RTL and testbench
===========================================

Name: yarp_instr_mem_responder

Overview:
Memory-side responder for the fetch interface. It accepts the core's instruction request (req + byte address) and returns the addressed 32-bit word after a fixed, parameterised latency. The word is returned with a valid flag and an error flag. It contains the word storage, a post-reset clear sequencer, and a preload port used by the boot loader or testbench to write program images.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, >= 16.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4 aligned.
READ_LATENCY, 1, cycles from accepted request to rd_valid; legal range 1..4.
NOP_INSTR, 32'h0000_0013, clear value and error-return data (ADDI x0,x0,0).
AW (local), $clog2(DEPTH), word index width.

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
mem_req_i  in  1  read request, sampled every clk
mem_addr_i  in  32  byte address of request
mem_rd_data_o  out  32  returned instruction word
mem_rd_valid_o  out  1  rd_data/rd_err valid this cycle
mem_rd_err_o  out  1  request was misaligned or out of range
mem_ready_o  out  1  init complete, requests serviced
load_en_i  in  1  preload write strobe
load_addr_i  in  AW  preload word index
load_data_i  in  32  preload data

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. All outputs are 0 during reset: rd_data=0, rd_valid=0, rd_err=0, ready=0. The FSM enters INIT with clear counter=0 and all latency-pipe valid bits cleared. Storage contents are not reset.
- FSM has two states, INIT and READY.
- INIT:
  - Each cycle writes NOP_INSTR to word[clear_cnt], then increments clear_cnt.
  - After writing index DEPTH-1, the FSM moves to READY. INIT lasts exactly DEPTH cycles after reset deassertion.
  - ready=0 throughout INIT. Requests are dropped (no rd_valid ever issued for them). load_en is ignored.
- READY:
  - ready=1 from the first READY cycle onward.
  - Stays in READY until reset.
- Reset mid-operation (INIT or READY): immediate return to INIT. In-flight responses are discarded, and their rd_valid never asserts.
- Request acceptance: a request is accepted in any READY cycle with req=1. There is no backpressure, so one request per cycle sustains full throughput.
- Address decode:
  - off = addr - BASE_ADDR.
  - err = (addr[1:0] != 0) OR (addr < BASE_ADDR) OR (off >= DEPTH*4).
  - Word index = off[AW+1:2].
- Response timing: for a request accepted in cycle N, the response appears in cycle N+READ_LATENCY with rd_valid=1.
  - No error: rd_data = stored word, rd_err=0.
  - Error: rd_data = NOP_INSTR, rd_err=1.
  - Responses stay in order. Cycles with no response have rd_valid=0, rd_err=0, and rd_data holding its last value.
- Implementation: synchronous array read in the accept cycle, followed by READ_LATENCY-1 pipeline registers carrying {valid, err, data}.
- Preload (READY only): load_en=1 writes load_data into word[load_addr] at the clock edge.
- Simultaneous preload and read of the same word in the same cycle: the read returns the OLD content (read-before-write). A read issued the following cycle returns the new data.
- Preload and read on different words in the same cycle both complete.

Test Plan:
- Reset release with DEPTH=16: ready rises exactly 16 cycles after reset_n goes 1. A req on addr 0x0 during INIT gets no rd_valid. After READY, a read of 0x3C returns 0x00000013 with err=0.
- Preload word 2 = 0xDEADBEEF, then req addr 0x8 at cycle N with READ_LATENCY=3: rd_valid=1 and data=0xDEADBEEF exactly at N+3, and rd_valid=0 at N+1, N+2, and N+4.
- Back-to-back req on 0x0, 0x4, 0x8 every cycle (words preloaded to 0x11, 0x22, 0x33), READ_LATENCY=1: rd_valid held high 3 consecutive cycles with data 0x11, 0x22, 0x33 in order.
- Error cases: addr 0x6 gives err=1 and data 0x00000013. With DEPTH=16, BASE_ADDR=0x100: addr 0xFC gives err=1, 0x140 gives err=1, and 0x13C gives err=0.
- Word 5 holds 0xAAAA0000. In the same cycle, load_en to index 5 with 0x12345678 and req on 0x14: response is 0xAAAA0000. A req in the next cycle returns 0x12345678.
- Assert reset_n=0 while two responses are in flight (READ_LATENCY=4): all outputs go to 0 immediately. No rd_valid appears after release, and the INIT sequence restarts for the full DEPTH cycles.

Source files
------------

// File: rtl/yarp_instr_mem_responder.sv
// yarp_instr_mem_responder
//   Memory-side responder for the instruction fetch interface. After reset it
//   clears every word to NOP_INSTR, one word per cycle, then asserts
//   mem_ready_o. From then on it services one read per cycle with a fixed
//   READ_LATENCY. It also accepts preload writes from the boot loader.
//
// Ports
//   clk, reset_n    clock, asynchronous active-low reset
//   mem_req_i       read request, sampled every clock
//   mem_addr_i      byte address of the request
//   mem_rd_data_o   returned word (NOP_INSTR on error, holds between responses)
//   mem_rd_valid_o  response valid this cycle
//   mem_rd_err_o    response is for a misaligned or out-of-range address
//   mem_ready_o     clear sequence finished, requests are serviced
//   load_en_i       preload write strobe (honoured only when ready)
//   load_addr_i     preload word index
//   load_data_i     preload data
module yarp_instr_mem_responder #(
  parameter int unsigned DEPTH        = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mem_req_i,
  input  logic [31:0]   mem_addr_i,
  output logic [31:0]   mem_rd_data_o,
  output logic          mem_rd_valid_o,
  output logic          mem_rd_err_o,
  output logic          mem_ready_o,
  input  logic          load_en_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [31:0]   load_data_i
);

  localparam logic [32:0]   SPAN_BYTES = 33'(DEPTH) * 33'd4;
  localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_clear_cnt;
  logic [AW-1:0]   w_clear_cnt_nxt;
  logic            r_ready;

  logic            w_accept;
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_waddr;
  logic [31:0]     w_mem_wdata;

  logic [31:0]     w_off;
  logic            w_err;
  logic [AW-1:0]   w_idx;

  logic [31:0]     r_mem [DEPTH];
  resp_t           r_pipe [READ_LATENCY];

  // Address decode: alignment, below-base and beyond-span checks
  assign w_off = mem_addr_i - BASE_ADDR;
  assign w_err = (mem_addr_i[1:0] != 2'b00) || (mem_addr_i < BASE_ADDR) ||
                 ({1'b0, w_off} >= SPAN_BYTES);
  assign w_idx = w_off[AW+1:2];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_INIT;
      r_clear_cnt <= '0;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clear_cnt <= w_clear_cnt_nxt;
      r_ready     <= (w_state_nxt == ST_READY);
    end
  end

  // Next state, clear sequencing, write-port and accept selection
  always_comb begin
    w_state_nxt     = r_state;
    w_clear_cnt_nxt = r_clear_cnt;
    w_accept        = 1'b0;
    w_mem_we        = 1'b0;
    w_mem_waddr     = r_clear_cnt;
    w_mem_wdata     = NOP_INSTR;
    case (r_state)
      ST_INIT: begin
        w_mem_we        = 1'b1;
        w_clear_cnt_nxt = r_clear_cnt + AW'(1);
        if (r_clear_cnt == LAST_IDX) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        w_accept = mem_req_i;
        if (load_en_i) begin
          w_mem_we    = 1'b1;
          w_mem_waddr = load_addr_i;
          w_mem_wdata = load_data_i;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Word storage; contents survive reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Response pipeline. Stage 0 samples the array in the accept cycle, so a
  // same-cycle preload to that word is seen by the read as the old content.
  // Data only advances with a valid beat so the output holds its last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0].valid <= w_accept;
      r_pipe[0].err   <= w_accept & w_err;
      if (w_accept) begin
        r_pipe[0].data <= w_err ? NOP_INSTR : r_mem[w_idx];
      end
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        r_pipe[i].valid <= r_pipe[i-1].valid;
        r_pipe[i].err   <= r_pipe[i-1].err;
        if (r_pipe[i-1].valid) begin
          r_pipe[i].data <= r_pipe[i-1].data;
        end
      end
    end
  end

  assign mem_rd_valid_o = r_pipe[READ_LATENCY-1].valid;
  assign mem_rd_err_o   = r_pipe[READ_LATENCY-1].err;
  assign mem_rd_data_o  = r_pipe[READ_LATENCY-1].data;
  assign mem_ready_o    = r_ready;

endmodule

// File: tb/tb_yarp_instr_mem_responder.sv
// Testbench for yarp_instr_mem_responder: directed scenarios plus random
// traffic, checked every cycle against a transaction-level reference model.
module tb_yarp_instr_mem_responder;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int unsigned RL    = 3;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          mem_req_i = 1'b0;
  logic [31:0]   mem_addr_i = '0;
  logic [31:0]   mem_rd_data_o;
  logic          mem_rd_valid_o;
  logic          mem_rd_err_o;
  logic          mem_ready_o;
  logic          load_en_i = 1'b0;
  logic [AW-1:0] load_addr_i = '0;
  logic [31:0]   load_data_i = '0;

  yarp_instr_mem_responder #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(RL), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i),
    .mem_rd_data_o(mem_rd_data_o), .mem_rd_valid_o(mem_rd_valid_o),
    .mem_rd_err_o(mem_rd_err_o), .mem_ready_o(mem_ready_o),
    .load_en_i(load_en_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          ecount = 0;
  int          since  = 0;
  logic        m_ready = 1'b0;
  logic [31:0] m_last  = '0;
  logic [31:0] m_mem [DEPTH];
  exp_t        q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then check after the edge
  task automatic step(input logic req, input logic [31:0] addr,
                      input logic ld, input int laddr, input logic [31:0] ldata);
    exp_t e;
    logic exp_v;
    logic exp_e;
    mem_req_i   = req;
    mem_addr_i  = addr;
    load_en_i   = ld;
    load_addr_i = AW'(laddr);
    load_data_i = ldata;
    if (m_ready && req) begin
      e.due = ecount + int'(RL);
      e.err = (addr % 4 != 0) || (addr < BASE) || (addr >= BASE + DEPTH * 4);
      e.data = e.err ? NOP : m_mem[(addr - BASE) / 4];
      q.push_back(e);
    end
    if (m_ready && ld) m_mem[laddr] = ldata;
    @(posedge clk);
    #1;
    ecount++;
    since++;
    if (!m_ready && since >= int'(DEPTH)) begin
      m_ready = 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = NOP;
    end
    exp_v = 1'b0;
    exp_e = 1'b0;
    if (q.size() > 0 && q[0].due == ecount) begin
      e = q.pop_front();
      exp_v  = 1'b1;
      exp_e  = e.err;
      m_last = e.data;
    end
    chk("rd_valid", 32'(mem_rd_valid_o), 32'(exp_v));
    chk("rd_err",   32'(mem_rd_err_o),   32'(exp_e));
    chk("rd_data",  mem_rd_data_o,       m_last);
    chk("ready",    32'(mem_ready_o),    32'(m_ready));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr);
    step(1'b1, addr, 1'b0, 0, 32'h0);
  endtask

  task automatic ld(input int idx, input logic [31:0] data);
    step(1'b0, 32'h0, 1'b1, idx, data);
  endtask

  // Asserted mid-cycle; outputs must clear without waiting for a clock edge
  task automatic do_reset();
    reset_n   = 1'b0;
    mem_req_i = 1'b0;
    load_en_i = 1'b0;
    #1;
    q.delete();
    m_ready = 1'b0;
    m_last  = '0;
    chk("rst_valid", 32'(mem_rd_valid_o), 32'd0);
    chk("rst_err",   32'(mem_rd_err_o),   32'd0);
    chk("rst_data",  mem_rd_data_o,       32'd0);
    chk("rst_ready", 32'(mem_ready_o),    32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      ecount++;
      chk("rst_hold_valid", 32'(mem_rd_valid_o), 32'd0);
      chk("rst_hold_ready", 32'(mem_ready_o),    32'd0);
    end
    #1;
    reset_n = 1'b1;
    since   = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return BASE - 32'($urandom_range(1, 64));
      1:       return BASE + DEPTH * 4 + 32'($urandom_range(0, 64));
      2:       return BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
      3:       return $urandom;
      default: return BASE + 4 * 32'($urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  initial begin
    #2;
    do_reset();

    // INIT: request dropped, ready rises after exactly DEPTH cycles
    rd(BASE);
    idle(int'(DEPTH) - 1);

    // Cleared word at top of range
    rd(BASE + 32'h3C);
    idle(int'(RL));

    // Preload then timed read
    ld(2, 32'hDEAD_BEEF);
    rd(BASE + 32'h8);
    idle(4);

    // Back-to-back reads
    ld(0, 32'h11);
    ld(1, 32'h22);
    ld(2, 32'h33);
    rd(BASE + 32'h0);
    rd(BASE + 32'h4);
    rd(BASE + 32'h8);
    idle(4);

    // Error decode boundaries
    rd(BASE + 32'h6);
    rd(BASE - 32'h4);
    rd(BASE + 32'h40);
    rd(BASE + 32'h3C);
    rd(32'hFFFF_FFFC);
    idle(4);

    // Read-before-write on the same word, new data on the next cycle
    ld(5, 32'hAAAA_0000);
    step(1'b1, BASE + 32'h14, 1'b1, 5, 32'h1234_5678);
    rd(BASE + 32'h14);
    // Preload and read of different words in the same cycle
    step(1'b1, BASE + 32'h18, 1'b1, 7, 32'h0BAD_F00D);
    rd(BASE + 32'h1C);
    idle(4);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), rand_addr(),
           1'($urandom_range(0, 3) == 0), int'($urandom_range(0, DEPTH - 1)), $urandom);
    end

    // Reset with two responses in flight; they must never surface
    rd(BASE + 32'h0);
    rd(BASE + 32'h4);
    do_reset();
    rd(BASE + 32'h8);
    idle(int'(DEPTH) + 2);
    rd(BASE + 32'h8);
    rd(BASE + 32'h9);
    idle(4);

    // Random traffic after re-init
    for (int i = 0; i < 150; i++) begin
      step(1'($urandom_range(0, 1)), rand_addr(),
           1'($urandom_range(0, 2) == 0), int'($urandom_range(0, DEPTH - 1)), $urandom);
    end
    idle(int'(RL) + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
